// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: two-flop synchroniser, press/release debounce FSM,
// registered LEVEL and a single-cycle PULSE on every accepted press.
module btn_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic BTN_IN,
    output logic LEVEL,
    output logic PULSE
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        CHK_PRESS,
        HELD,
        CHK_REL
    } state_t;

    state_t        state;
    state_t        state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          level_n;
    logic          pulse_n;
    logic          btn;
    logic          s1;
    logic          s2;

    assign btn = BTN_IN ^ BTN_ACTIVE_LOW;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= btn;
            s2 <= s1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
            cnt   <= '0;
            LEVEL <= 1'b0;
            PULSE <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            LEVEL <= level_n;
            PULSE <= pulse_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        level_n = LEVEL;
        pulse_n = 1'b0;
        case (state)
            IDLE: begin
                level_n = 1'b0;
                if (s2) begin
                    state_n = CHK_PRESS;
                    cnt_n   = '0;
                end
            end
            CHK_PRESS: begin
                level_n = 1'b0;
                if (!s2) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = HELD;
                    cnt_n   = '0;
                    level_n = 1'b1;
                    pulse_n = 1'b1;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            HELD: begin
                level_n = 1'b1;
                if (!s2) begin
                    state_n = CHK_REL;
                    cnt_n   = '0;
                end
            end
            CHK_REL: begin
                level_n = 1'b1;
                // A release bounce returns to HELD without re-pulsing
                if (s2) begin
                    state_n = HELD;
                    cnt_n   = '0;
                end else if (cnt == LAST) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    level_n = 1'b0;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                level_n = 1'b0;
                pulse_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// Directed bench for btn_debounce_pulse with DEBOUNCE_CYCLES=4, active-low pin.
module tb_btn_debounce_pulse;

    logic CLK = 1'b0;
    logic RST;
    logic BTN_IN;
    logic LEVEL;
    logic PULSE;

    int total = 0;
    int bad   = 0;
    int npulse = 0;
    int wide  = 0;
    int base;
    logic prev_p = 1'b0;

    btn_debounce_pulse #(
        .DEBOUNCE_CYCLES(4),
        .BTN_ACTIVE_LOW(1'b1)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .BTN_IN(BTN_IN),
        .LEVEL(LEVEL),
        .PULSE(PULSE)
    );

    always #5 CLK = ~CLK;

    // Downstream counter model: counts pulses, flags any multi-cycle pulse
    always @(negedge CLK) begin
        if (PULSE) npulse++;
        if (PULSE && prev_p) wide++;
        prev_p = PULSE;
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        RST    = 1'b1;
        BTN_IN = 1'b1;

        // Reset holds outputs low while the pin toggles
        for (int i = 0; i < 4; i++) begin
            BTN_IN = ~BTN_IN;
            step(1);
            chk("rst_level", {31'd0, LEVEL}, 32'd0);
            chk("rst_pulse", {31'd0, PULSE}, 32'd0);
        end
        BTN_IN = 1'b1;
        step(1);
        RST    = 1'b0;
        BTN_IN = 1'b0;
        step(7);
        chk("pre_async_pulse", {31'd0, PULSE}, 32'd1);
        #2;
        RST = 1'b1;
        #1;
        chk("async_pulse", {31'd0, PULSE}, 32'd0);
        chk("async_level", {31'd0, LEVEL}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            BTN_IN = ~BTN_IN;
            step(1);
            chk("rst_tog_level", {31'd0, LEVEL}, 32'd0);
        end
        BTN_IN = 1'b1;
        step(1);
        RST  = 1'b0;
        base = npulse;
        step(20);
        chk("post_rst_pulses", npulse - base, 32'd0);
        chk("post_rst_level", {31'd0, LEVEL}, 32'd0);

        // Clean press
        base   = npulse;
        BTN_IN = 1'b0;
        step(6);
        chk("press_e6_level", {31'd0, LEVEL}, 32'd0);
        chk("press_e6_pulse", {31'd0, PULSE}, 32'd0);
        step(1);
        chk("press_e7_level", {31'd0, LEVEL}, 32'd1);
        chk("press_e7_pulse", {31'd0, PULSE}, 32'd1);
        step(1);
        chk("press_e8_pulse", {31'd0, PULSE}, 32'd0);
        chk("press_e8_level", {31'd0, LEVEL}, 32'd1);
        step(22);
        chk("press_count", npulse - base, 32'd1);

        // Two-cycle release glitch is ignored
        BTN_IN = 1'b1;
        step(2);
        BTN_IN = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            chk("relglitch_level", {31'd0, LEVEL}, 32'd1);
        end
        chk("relglitch_count", npulse - base, 32'd1);

        // Clean release
        BTN_IN = 1'b1;
        step(6);
        chk("rel_e6_level", {31'd0, LEVEL}, 32'd1);
        step(1);
        chk("rel_e7_level", {31'd0, LEVEL}, 32'd0);
        chk("rel_e7_pulse", {31'd0, PULSE}, 32'd0);
        step(13);
        chk("rel_count", npulse - base, 32'd1);

        // Bounce: 3 low / 2 high, five times, then stable low
        base = npulse;
        for (int i = 0; i < 5; i++) begin
            BTN_IN = 1'b0;
            step(3);
            BTN_IN = 1'b1;
            step(2);
        end
        chk("bounce_count", npulse - base, 32'd0);
        chk("bounce_level", {31'd0, LEVEL}, 32'd0);
        BTN_IN = 1'b0;
        step(6);
        chk("bounce_e6_pulse", {31'd0, PULSE}, 32'd0);
        step(1);
        chk("bounce_e7_pulse", {31'd0, PULSE}, 32'd1);
        chk("bounce_e7_level", {31'd0, LEVEL}, 32'd1);
        step(10);
        chk("bounce_final", npulse - base, 32'd1);

        // Reset during CHK_PRESS with the button held
        BTN_IN = 1'b1;
        step(10);
        chk("midrst_idle", {31'd0, LEVEL}, 32'd0);
        base   = npulse;
        BTN_IN = 1'b0;
        step(4);
        RST = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1);
            chk("midrst_pulse", {31'd0, PULSE}, 32'd0);
        end
        RST = 1'b0;
        step(6);
        chk("midrst_e6_pulse", {31'd0, PULSE}, 32'd0);
        step(1);
        chk("midrst_e7_pulse", {31'd0, PULSE}, 32'd1);
        chk("midrst_e7_level", {31'd0, LEVEL}, 32'd1);
        step(1);
        chk("midrst_e8_pulse", {31'd0, PULSE}, 32'd0);
        chk("midrst_count", npulse - base, 32'd1);

        // Three clean presses
        BTN_IN = 1'b1;
        step(20);
        base = npulse;
        for (int i = 0; i < 3; i++) begin
            BTN_IN = 1'b0;
            step(10);
            BTN_IN = 1'b1;
            step(20);
        end
        chk("repeat_count", npulse - base, 32'd3);
        chk("repeat_level", {31'd0, LEVEL}, 32'd0);
        chk("pulse_width", wide, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
